// File: rtl/sboxd_sched.sv
// Time-shared AES inverse S-box layer: two requesters, round-robin grant, 4 beats of 32 bits.
// Optional macro SBXSEQ_SECURE_CLEAR_EN hides partial/stale state on rsp_data and clears work after use.

module sboxinverse (
  input  logic [7:0] value,
  output logic [7:0] result
);
  // Leftmost entry is the image of 0x00; the index is inverted to match packed ordering.
  localparam logic [255:0][7:0] TABLE = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  logic [7:0] idx;
  assign idx    = ~value;
  assign result = TABLE[idx];
endmodule

module sboxd_sched #(
  parameter int PRIO_INIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [127:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [127:0] req1_data,
  output logic         req1_ready,
  output logic         rsp_valid,
  output logic [127:0] rsp_data,
  output logic         rsp_id,
  input  logic         rsp_ready,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t       state;
  logic [127:0] work;
  logic [1:0]   beat;
  logic         rr;
  logic         grant0;
  logic         grant1;
  logic [31:0]  cur_word;
  logic [31:0]  sub_word;

  // rr names the requester that wins when both are valid.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | ~rr);
    grant1 = req1_valid & (~req0_valid | rr);
  end

  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;

  always_comb begin
    cur_word = work[127:96];
    case (beat)
      2'd0: cur_word = work[127:96];
      2'd1: cur_word = work[95:64];
      2'd2: cur_word = work[63:32];
      2'd3: cur_word = work[31:0];
      default: cur_word = work[127:96];
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    sboxinverse u_sbox (
      .value  (cur_word[8*i +: 8]),
      .result (sub_word[8*i +: 8])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      beat      <= 2'd0;
      rr        <= 1'(PRIO_INIT);
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            work   <= req0_ready ? req0_data : req1_data;
            rsp_id <= req1_ready;
            rr     <= req0_ready;
            beat   <= 2'd0;
            busy   <= 1'b1;
            state  <= SUB;
          end
        end
        SUB: begin
          case (beat)
            2'd0: work[127:96] <= sub_word;
            2'd1: work[95:64]  <= sub_word;
            2'd2: work[63:32]  <= sub_word;
            2'd3: work[31:0]   <= sub_word;
            default: work[127:96] <= sub_word;
          endcase
          beat <= beat + 2'd1;
          if (beat == 2'd3) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
`ifdef SBXSEQ_SECURE_CLEAR_EN
            work      <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SBXSEQ_SECURE_CLEAR_EN
  assign rsp_data = rsp_valid ? work : '0;
`else
  assign rsp_data = work;
`endif
endmodule

// File: tb/tb_sboxd_sched.sv
// Directed self-checking bench for sboxd_sched: reset, lanes, arbitration, backpressure, mid-op reset.
// Expected results follow SBXSEQ_SECURE_CLEAR_EN when the bench is built with it.

module tb_sboxd_sched;
  logic         clk;
  logic         rst;
  logic         req0_valid;
  logic [127:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [127:0] req1_data;
  logic         req1_ready;
  logic         rsp_valid;
  logic [127:0] rsp_data;
  logic         rsp_id;
  logic         rsp_ready;
  logic         busy;

  int total;
  int bad;

  localparam logic [127:0] ALL63     = {16{8'h63}};
  localparam logic [127:0] ALL00     = '0;
  localparam logic [127:0] ALL52     = {16{8'h52}};
  localparam logic [127:0] LANE_IN   = 128'h0000_0000_7C7C_7C7C_FFFF_FFFF_6363_6363;
  localparam logic [127:0] LANE_OUT  = 128'h5252_5252_0101_0101_7D7D_7D7D_0000_0000;
  localparam logic [127:0] LANE_PART = 128'h5252_5252_7C7C_7C7C_FFFF_FFFF_6363_6363;
  localparam logic [127:0] BP_IN     = 128'h6363_6363_0000_0000_7C7C_7C7C_FFFF_FFFF;
  localparam logic [127:0] BP_OUT    = 128'h0000_0000_5252_5252_0101_0101_7D7D_7D7D;

  sboxd_sched #(.PRIO_INIT(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Presents one request, waits for its grant, and returns just after the accept edge.
  task automatic wait_accept(input bit id, input logic [127:0] d, output bit timed_out);
    bit got;
    got = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_data = d; end
    else    begin req0_valid = 1'b1; req0_data = d; end
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if ((id && req1_ready) || (!id && req0_ready)) got = 1'b1;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    timed_out = !got;
  endtask

  // Counts edges after the accept edge until rsp_valid shows up.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; rsp_ready = 1'b0;
    #12;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_data !== 128'h0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready_idle got=%b exp=00", {req0_ready, req1_ready}); end
    req0_valid = 1'b1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL reset_ready_follows_grant got=%b exp=10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_arbitration;
    int gid[4];
    int gcyc[4];
    int n;
    int both;
    int k;
    n = 0; both = 0;
    rsp_ready = 1'b1;
    req0_data = ALL63; req1_data = ALL00;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
      #1;
      if (req0_ready && req1_ready) both++;
      if (req0_ready || req1_ready) begin
        gid[n] = req1_ready ? 1 : 0;
        gcyc[n] = cyc;
        n++;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    k = 0;
    while (busy && k < 20) begin @(posedge clk); #1; k++; end
    total++; if (n != 4) begin bad++; $display("FAIL arb_grant_count got=%0d exp=4", n); end
    for (int i = 0; i < n; i++) begin
      total++;
      if (gid[i] != (i % 2)) begin bad++; $display("FAIL arb_order[%0d] got=%0d exp=%0d", i, gid[i], i % 2); end
    end
    for (int i = 1; i < n; i++) begin
      total++;
      if (gcyc[i] - gcyc[i-1] != 6) begin bad++; $display("FAIL arb_spacing[%0d] got=%0d exp=6", i, gcyc[i] - gcyc[i-1]); end
    end
    total++; if (both != 0) begin bad++; $display("FAIL arb_both_ready got=%0d exp=0", both); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arb_drain_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic;
    bit to;
    int lat;
    logic [127:0] exp_after;
    rsp_ready = 1'b1;
    wait_accept(1'b0, ALL63, to);
    total++; if (to) begin bad++; $display("FAIL basic_accept0 got=timeout exp=accept"); end
    wait_rsp(lat);
    total++; if (lat != 4) begin bad++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    total++; if (rsp_data !== ALL00) begin bad++; $display("FAIL basic_data63 got=%h exp=%h", rsp_data, ALL00); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL basic_id got=%b exp=0", rsp_id); end
    @(posedge clk); #1;
    wait_accept(1'b0, ALL00, to);
    total++; if (to) begin bad++; $display("FAIL basic_accept1 got=timeout exp=accept"); end
    wait_rsp(lat);
    total++; if (rsp_data !== ALL52) begin bad++; $display("FAIL basic_data00 got=%h exp=%h", rsp_data, ALL52); end
    @(posedge clk); #1;
`ifdef SBXSEQ_SECURE_CLEAR_EN
    exp_after = '0;
`else
    exp_after = ALL52;
`endif
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_after got=%b exp=0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    total++; if (rsp_data !== exp_after) begin bad++; $display("FAIL basic_data_after got=%h exp=%h", rsp_data, exp_after); end
  endtask

  task automatic test_lanes;
    bit to;
    int lat;
    logic [127:0] exp_part;
    rsp_ready = 1'b1;
    wait_accept(1'b1, LANE_IN, to);
    total++; if (to) begin bad++; $display("FAIL lanes_accept got=timeout exp=accept"); end
    @(posedge clk); #1;
`ifdef SBXSEQ_SECURE_CLEAR_EN
    exp_part = '0;
`else
    exp_part = LANE_PART;
`endif
    total++; if (rsp_data !== exp_part) begin bad++; $display("FAIL lanes_partial got=%h exp=%h", rsp_data, exp_part); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL lanes_busy_sub got=%b exp=1", busy); end
    wait_rsp(lat);
    total++; if (lat != 3) begin bad++; $display("FAIL lanes_latency got=%0d exp=3", lat); end
    total++; if (rsp_data !== LANE_OUT) begin bad++; $display("FAIL lanes_data got=%h exp=%h", rsp_data, LANE_OUT); end
    total++; if (rsp_id !== 1'b1) begin bad++; $display("FAIL lanes_id got=%b exp=1", rsp_id); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    bit to;
    int lat;
    rsp_ready = 1'b0;
    wait_accept(1'b0, BP_IN, to);
    total++; if (to) begin bad++; $display("FAIL bp_accept got=timeout exp=accept"); end
    wait_rsp(lat);
    total++; if (lat != 4) begin bad++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    req1_valid = 1'b1; req1_data = ALL63;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, rsp_valid); end
      total++; if (rsp_data !== BP_OUT) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, rsp_data, BP_OUT); end
      total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL bp_id[%0d] got=%b exp=0", i, rsp_id); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy[%0d] got=%b exp=1", i, busy); end
      total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, {req0_ready, req1_ready}); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_release_busy got=%b exp=0", busy); end
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL bp_release_idle got=%b exp=1", req1_ready); end
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_midop;
    bit to;
    int lat;
    int stray;
    rsp_ready = 1'b1;
    wait_accept(1'b0, ALL63, to);
    total++; if (to) begin bad++; $display("FAIL midop_accept got=timeout exp=accept"); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midop_busy got=%b exp=0", busy); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midop_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_data !== 128'h0) begin bad++; $display("FAIL midop_data got=%h exp=0", rsp_data); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL midop_id got=%b exp=0", rsp_id); end
    @(posedge clk); #1;
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL midop_no_response got=%0d exp=0", stray); end
    req0_valid = 1'b1; req0_data = LANE_IN;
    req1_valid = 1'b1; req1_data = ALL63;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL midop_rr_init got=%b exp=10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(lat);
    total++; if (lat != 4) begin bad++; $display("FAIL midop_fresh_latency got=%0d exp=4", lat); end
    total++; if (rsp_data !== LANE_OUT) begin bad++; $display("FAIL midop_fresh_data got=%h exp=%h", rsp_data, LANE_OUT); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL midop_fresh_id got=%b exp=0", rsp_id); end
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset;
    test_arbitration;
    test_basic;
    test_lanes;
    test_backpressure;
    test_reset_midop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
